// File: rtl/up_down_mod_counter.sv
// Modulo-MOD up/down counter with parallel load, wrap/saturate mode and
// registered overflow/underflow pulses. Define UDC_STEP_EN to add the step input.
module up_down_mod_counter #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned MOD    = 200,
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              up,
  input  logic              sat,
  input  logic              load,
  input  logic [BITS-1:0]   load_val,
`ifdef UDC_STEP_EN
  input  logic [STEP_W-1:0] step,
`endif
  output logic [BITS-1:0]   Q,
  output logic              at_max,
  output logic              at_min,
  output logic              ovf,
  output logic              unf
);

  // One extra bit so Q+s and Q+MOD-s never overflow.
  localparam int unsigned W = BITS + 1;
  localparam logic [W-1:0] ModW = W'(MOD);
  localparam logic [W-1:0] MaxW = W'(MOD - 1);

  logic [BITS-1:0] q_q, q_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [W-1:0] q_ext;
  logic [W-1:0] s_ext;
  logic [W-1:0] sum;
  logic [W-1:0] ld_ext;

`ifdef UDC_STEP_EN
  assign s_ext = W'(step);
`else
  assign s_ext = W'(1);
`endif

  assign q_ext  = {1'b0, q_q};
  assign ld_ext = {1'b0, load_val};
  assign sum    = q_ext + s_ext;

  always_comb begin
    q_d   = q_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (load) begin
      q_d = (ld_ext > MaxW) ? MaxW[BITS-1:0] : load_val;
    end else if (enable) begin
      if (up) begin
        if (sum > MaxW) begin
          ovf_d = 1'b1;
          q_d   = sat ? MaxW[BITS-1:0] : BITS'(sum - ModW);
        end else begin
          q_d = BITS'(sum);
        end
      end else begin
        if (q_ext < s_ext) begin
          unf_d = 1'b1;
          q_d   = sat ? '0 : BITS'(q_ext + ModW - s_ext);
        end else begin
          q_d = BITS'(q_ext - s_ext);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign Q      = q_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign at_max = (q_ext == MaxW);
  assign at_min = (q_q == '0);

endmodule

// File: tb/tb_up_down_mod_counter.sv
// Scoreboard bench for up_down_mod_counter at BITS=4, MOD=10; step tests
// run only when UDC_STEP_EN is defined.
module tb_up_down_mod_counter;

  localparam int unsigned BITS   = 4;
  localparam int unsigned MOD    = 10;
  localparam int unsigned STEP_W = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b0;
  logic            up = 1'b0;
  logic            sat = 1'b0;
  logic            load = 1'b0;
  logic [BITS-1:0] load_val = '0;
  logic [STEP_W-1:0] step = STEP_W'(1);
  logic [BITS-1:0] Q;
  logic            at_max, at_min, ovf, unf;

  up_down_mod_counter #(
    .BITS  (BITS),
    .MOD   (MOD),
    .STEP_W(STEP_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .up      (up),
    .sat     (sat),
    .load    (load),
    .load_val(load_val),
`ifdef UDC_STEP_EN
    .step    (step),
`endif
    .Q       (Q),
    .at_max  (at_max),
    .at_min  (at_min),
    .ovf     (ovf),
    .unf     (unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit o;
    bit u;
  } exp_t;

  exp_t sb[$];
  int   m_q = 0;
  int   checks = 0;
  int   failures = 0;
  int   pulses;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model of one edge; result goes to the scoreboard.
  task automatic drive(input string tag, input bit rst, input bit ld, input int lv,
                       input bit en, input bit u, input bit sa, input int st);
    exp_t e;
    e.o = 0;
    e.u = 0;
    if (rst) e.q = 0;
    else if (ld) e.q = (lv > MOD - 1) ? MOD - 1 : lv;
    else if (!en) e.q = m_q;
    else if (u) begin
      if (m_q + st > MOD - 1) begin
        e.o = 1;
        e.q = sa ? MOD - 1 : m_q + st - MOD;
      end else e.q = m_q + st;
    end else begin
      if (m_q < st) begin
        e.u = 1;
        e.q = sa ? 0 : m_q + MOD - st;
      end else e.q = m_q - st;
    end
    m_q = e.q;
    sb.push_back(e);
    reset = rst; load = ld; load_val = BITS'(lv);
    enable = en; up = u; sat = sa; step = STEP_W'(st);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".Q"}, int'(Q), e.q);
    check({tag, ".ovf"}, int'(ovf), int'(e.o));
    check({tag, ".unf"}, int'(unf), int'(e.u));
    check({tag, ".at_max"}, int'(at_max), int'(e.q == MOD - 1));
    check({tag, ".at_min"}, int'(at_min), int'(e.q == 0));
  endtask

  initial begin
    @(negedge clk);
    drive("reset", 1, 0, 0, 0, 0, 0, 1);

    // Wrap up through 9->0: exactly one ovf pulse, end at 2.
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      drive("up_wrap", 0, 0, 0, 1, 1, 0, 1);
      pulses += int'(ovf);
    end
    check("up_wrap.pulses", pulses, 1);
    check("up_wrap.final", int'(Q), 2);

    drive("ld0", 0, 1, 0, 0, 0, 0, 1);
    drive("down_wrap", 0, 0, 0, 1, 0, 0, 1);
    check("down_wrap.q9", int'(Q), 9);
    drive("down_after", 0, 0, 0, 1, 0, 0, 1);
    drive("ld0b", 0, 1, 0, 0, 0, 0, 1);
    drive("down_sat1", 0, 0, 0, 1, 0, 1, 1);
    drive("down_sat2", 0, 0, 0, 1, 0, 1, 1);

    drive("ld8", 0, 1, 8, 0, 0, 1, 1);
    drive("up_sat1", 0, 0, 0, 1, 1, 1, 1);
    drive("up_sat2", 0, 0, 0, 1, 1, 1, 1);
    drive("up_sat3", 0, 0, 0, 1, 1, 1, 1);
    check("up_sat.q9", int'(Q), 9);

    drive("ld15", 0, 1, 15, 0, 0, 0, 1);
    drive("ld_en", 0, 1, 3, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) drive("hold", 0, 0, 0, 0, 1, 0, 1);
    check("hold.q3", int'(Q), 3);
    drive("mode_sw", 0, 0, 0, 1, 0, 1, 1);

    drive("ld7", 0, 1, 7, 0, 0, 0, 1);
    drive("rst_mid", 1, 1, 5, 1, 1, 0, 1);
    check("rst_mid.q0", int'(Q), 0);
    drive("resume", 0, 0, 0, 1, 1, 0, 1);

`ifdef UDC_STEP_EN
    drive("st_rst", 1, 0, 0, 0, 0, 0, 4);
    for (int i = 0; i < 4; i++) drive("st_up4", 0, 0, 0, 1, 1, 0, 4);
    check("st_up4.q6", int'(Q), 6);
    drive("st_ld1", 0, 1, 1, 0, 0, 0, 3);
    drive("st_dn3", 0, 0, 0, 1, 0, 0, 3);
    check("st_dn3.q8", int'(Q), 8);
    drive("st_zero", 0, 0, 0, 1, 1, 0, 0);
    drive("st_sat", 0, 0, 0, 1, 1, 1, 4);
`endif

    check("sb.empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
